// File: rtl/ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer_if
// Bundles the decoder/memory handshake and status signals of the control
// sequencer so the sequencer and its environment connect through one port.
//   master : environment side (drives instruction/decoder/memory inputs,
//            observes the sequencer status)
//   slave  : sequencer side
// Signals:
//   instr_in, instr_valid                 instruction word and its valid
//   needs_exec2, needs_mem, mem_ready     decoder hints and data-memory ready
//   stop_req, stack_overflow, cond_pass   halt causes
//   resume                                request to leave HALT
//   instr_q, state, pc_cnt_en, halted,    sequencer status
//   fault, retired
// ---------------------------------------------------------------------------
interface ctrl_sequencer_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 16
);
  logic [INSTR_W-1:0] instr_in;
  logic               instr_valid;
  logic               needs_exec2;
  logic               needs_mem;
  logic               mem_ready;
  logic               stop_req;
  logic               stack_overflow;
  logic               cond_pass;
  logic               resume;

  logic [INSTR_W-1:0] instr_q;
  logic [1:0]         state;
  logic               pc_cnt_en;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   retired;

  modport master (
    output instr_in, instr_valid, needs_exec2, needs_mem, mem_ready,
           stop_req, stack_overflow, cond_pass, resume,
    input  instr_q, state, pc_cnt_en, halted, fault, retired
  );

  modport slave (
    input  instr_in, instr_valid, needs_exec2, needs_mem, mem_ready,
           stop_req, stack_overflow, cond_pass, resume,
    output instr_q, state, pc_cnt_en, halted, fault, retired
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Instruction sequencing FSM: FETCH -> EXEC1 -> (EXEC2) -> FETCH, with a HALT
// state entered on stop/stack-overflow or on a data-memory timeout.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : ctrl_sequencer_if.slave (instruction, decoder, memory inputs;
//              instr_q/state/fault/retired registered, pc_cnt_en/halted
//              combinational)
// Parameters:
//   INSTR_W  : instruction width
//   CNT_W    : retired-instruction counter width (wraps silently)
//   MAX_WAIT : data-memory wait limit in cycles (1..255)
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  ctrl_sequencer_if.slave   bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  state_e             r_state;
  logic [INSTR_W-1:0] r_instr_q;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_fault;
  logic [CNT_W-1:0]   r_retired;

  logic w_halt_req;
  logic w_mem_wait;
  logic w_timeout;
  logic w_pc_cnt_en;

  // EXEC1 decode terms; only consulted while in EXEC1
  assign w_halt_req = bus.stop_req | (bus.stack_overflow & bus.cond_pass);
  assign w_mem_wait = bus.needs_mem & ~bus.mem_ready;
  // The current wait cycle is the MAX_WAIT-th one: counter would reach MAX_WAIT
  assign w_timeout  = (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Sequencer state, instruction latch, wait counter, fault and retire count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_FETCH;
      r_instr_q  <= '0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.instr_valid) begin
            r_instr_q <= bus.instr_in;
            r_state   <= ST_EXEC1;
          end
        end

        // Priority: halt request, memory wait (with timeout), EXEC2, retire
        ST_EXEC1: begin
          if (w_halt_req) begin
            r_state    <= ST_HALT;
            r_wait_cnt <= '0;
          end else if (w_mem_wait) begin
            if (w_timeout) begin
              r_fault    <= 1'b1;
              r_state    <= ST_HALT;
              r_wait_cnt <= '0;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
          end else if (bus.needs_exec2) begin
            r_state    <= ST_EXEC2;
            r_wait_cnt <= '0;
          end else begin
            r_state    <= ST_FETCH;
            r_retired  <= r_retired + CNT_W'(1);
            r_wait_cnt <= '0;
          end
        end

        ST_EXEC2: begin
          r_state   <= ST_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end

        // A memory fault is sticky: only reset leaves HALT then
        ST_HALT: begin
          if (bus.resume && !r_fault) begin
            r_state <= ST_FETCH;
          end
        end

        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // PC strobe: FETCH accept, or EXEC1 consuming the immediate word.
  // Suppressed while reset is asserted since no accept happens on that edge.
  always_comb begin
    w_pc_cnt_en = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_FETCH: w_pc_cnt_en = bus.instr_valid;
        ST_EXEC1: w_pc_cnt_en = ~w_halt_req & ~w_mem_wait & bus.needs_exec2;
        default:  w_pc_cnt_en = 1'b0;
      endcase
    end
  end

  assign bus.instr_q   = r_instr_q;
  assign bus.state     = r_state;
  assign bus.pc_cnt_en = w_pc_cnt_en;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.fault     = r_fault;
  assign bus.retired   = r_retired;

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter INSTR_W, default 16, instruction word width.
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 Parameter MAX_WAIT, default 15, data-memory wait limit in cycles (range 1..255).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 instr_in  in  INSTR_W  instruction word from instruction RAM.
REQ-007 instr_valid  in  1  instr_in valid this cycle.
REQ-008 needs_exec2  in  1  decoder: current instruction requires EXEC2.
REQ-009 needs_mem  in  1  decoder: current instruction accesses data memory in EXEC1.
REQ-010 mem_ready  in  1  data-memory access complete.
REQ-011 stop_req  in  1  decoder: stop instruction executing.
REQ-012 stack_overflow  in  1  stack pointer overflow.
REQ-013 cond_pass  in  1  condition field evaluated true.
REQ-014 resume  in  1  request exit from HALT.
REQ-015 instr_q  out  INSTR_W  latched current instruction.
REQ-016 state  out  2  FETCH=00, EXEC1=01, EXEC2=10, HALT=11.
REQ-017 pc_cnt_en  out  1  program-counter increment strobe.
REQ-018 halted  out  1  high while in HALT.
REQ-019 fault  out  1  sticky memory-timeout flag.
REQ-020 retired  out  CNT_W  count of completed instructions.

Function
REQ-021 FETCH: instr_valid=0 -> stay; instr_valid=1 -> load instr_q, pc_cnt_en=1 that cycle, next EXEC1.
REQ-022 EXEC1 priority, highest first: halt condition, memory wait, EXEC2, FETCH.
REQ-023 Halt condition in EXEC1: stop_req=1, or (stack_overflow=1 and cond_pass=1) -> next HALT; retired not incremented.
REQ-024 Memory wait: needs_mem=1 and mem_ready=0 -> stay EXEC1, wait counter +1.
REQ-025 Wait counter reaching MAX_WAIT while mem_ready=0 -> fault=1, next HALT, no retire.
REQ-026 needs_exec2=1 (no halt, no wait) -> next EXEC2; pc_cnt_en=1 that cycle (immediate word consumed).
REQ-027 needs_exec2=0 (no halt, no wait) -> next FETCH, retired +1.
REQ-028 EXEC2: single cycle, unconditionally next FETCH, retired +1.
REQ-029 Wait counter cleared on every exit from EXEC1; width ceil(log2(MAX_WAIT+1)).
REQ-030 HALT: pc_cnt_en=0, instr_q held; resume=1 and fault=0 -> next FETCH; resume ignored when fault=1.
REQ-031 halted combinational from state (state==11).
REQ-032 pc_cnt_en combinational, asserted only per REQ-021/REQ-026; never in HALT or during memory wait.
REQ-033 retired wraps modulo 2^CNT_W without flag.
REQ-034 instr_q changes only on FETCH accept; decoder inputs sampled only in EXEC1 (EXEC2 ignores them).
REQ-035 stop_req and stack_overflow ignored outside EXEC1.
REQ-036 Encoding 11 unreachable except as HALT; no other illegal states exist.

Reset
REQ-037 reset_n=0 at a rising edge -> state=FETCH, instr_q=0, retired=0, fault=0, wait counter=0, pc_cnt_en=0, halted=0.
REQ-038 Reset overrides any state including HALT with fault=1 and mid-memory-wait.
REQ-039 First instruction accepted no earlier than the first edge after reset_n returns high.

Verification
REQ-040 Single-cycle op: instr_valid=1 instr_in=16'h4123, needs_exec2=0 -> states 00,01,00; instr_q=4123; retired=1; pc_cnt_en one pulse.
REQ-041 Two-word op: needs_exec2=1 -> states 00,01,10,00; pc_cnt_en pulses in FETCH and EXEC1; retired=1 after EXEC2.
REQ-042 Memory wait: needs_mem=1, mem_ready low 3 cycles then high -> 4 cycles in EXEC1, no pc_cnt_en during wait, then FETCH, retired+1.
REQ-043 Timeout: MAX_WAIT=15, mem_ready held 0 -> fault=1 and state=11 after 15 wait cycles; resume=1 ignored; reset_n=0 clears fault, state=00.
REQ-044 Stop/overflow: stop_req=1 in EXEC1 -> HALT, retired unchanged; resume=1 -> FETCH; stack_overflow=1 with cond_pass=0 -> no halt.
REQ-045 Wrap: CNT_W=4, retire 16 instructions -> retired returns to 0.
